inst_mem_loader: RTL

//  Writer side of the byte-addressed instruction memory. Receives a program as a

---
 rtl/inst_mem_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : inst_mem_loader                                           |
// | Brief    : loads a length-prefixed byte stream into instruction      |
// |            memory, NOP-pads the last word and gates the CPU stall    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module inst_mem_loader #(
  parameter int          WORD  = 8,
  parameter int          PCL   = 32,
  parameter int          DEPTH = 1024,
  parameter logic [31:0] NOP   = 32'h0400_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WORD-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            mem_we,
  output logic [PCL-1:0]  mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic            cpu_hold,
  output logic            done,
  output logic            error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_PAD  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_len;
  logic [1:0]      r_hdr_cnt;
  logic [PCL-1:0]  r_addr;
  logic            r_mem_we;
  logic [PCL-1:0]  r_mem_addr;
  logic [WORD-1:0] r_mem_wdata;

  logic            w_rx_en;
  logic            w_accept;
  logic            w_hdr_last;
  logic            w_load_last;
  logic [31:0]     w_len_nxt;
  logic [PCL-1:0]  w_addr_inc;
  logic [WORD-1:0] w_pad_byte;

  assign w_rx_en     = (r_state == S_HDR) || (r_state == S_LOAD);
  assign w_accept    = in_valid & w_rx_en;
  assign w_hdr_last  = (r_hdr_cnt == 2'd3);
  assign w_len_nxt   = {r_len[31-WORD:0], in_data};
  assign w_addr_inc  = r_addr + {{(PCL-1){1'b0}}, 1'b1};
  assign w_load_last = (w_addr_inc == PCL'(r_len));

  // Pad byte k of the NOP word sits at the k-th lowest address (big-endian)
  always_comb begin
    w_pad_byte = WORD'(NOP[31:24]);
    case (r_addr[1:0])
      2'd0:    w_pad_byte = WORD'(NOP[31:24]);
      2'd1:    w_pad_byte = WORD'(NOP[23:16]);
      2'd2:    w_pad_byte = WORD'(NOP[15:8]);
      default: w_pad_byte = WORD'(NOP[7:0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    cpu_hold    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_HDR;
      end
      S_HDR: begin
        in_ready = 1'b1;
        if (w_accept && w_hdr_last) begin
          if (w_len_nxt == 32'd0)             w_state_nxt = S_DONE;
          else if (w_len_nxt > 32'(DEPTH))    w_state_nxt = S_ERR;
          else                                w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (w_accept && w_load_last) begin
          w_state_nxt = (w_addr_inc[1:0] == 2'd0) ? S_DONE : S_PAD;
        end
      end
      S_PAD: begin
        if (w_addr_inc[1:0] == 2'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // The final write is still on the bus in the first DONE cycle
        done     = ~r_mem_we;
        cpu_hold = r_mem_we;
        if (start) w_state_nxt = S_HDR;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) w_state_nxt = S_HDR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len       <= 32'd0;
      r_hdr_cnt   <= 2'd0;
      r_addr      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_len     <= 32'd0;
            r_hdr_cnt <= 2'd0;
            r_addr    <= '0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_len     <= w_len_nxt;
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            r_addr    <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= in_data;
            r_addr      <= w_addr_inc;
          end
        end
        S_PAD: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_addr;
          r_mem_wdata <= w_pad_byte;
          r_addr      <= w_addr_inc;
        end
        default: begin
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
